// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the SerDes FIFO read-side framer.
//   state_t            : framer FSM states
//   K28_5/K27_7/K29_7  : default 8b/10b control symbols for IDLE/SOF/EOF
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SOF  = 2'd1,
        S_DATA = 2'd2,
        S_EOF  = 2'd3
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that absorbs the one-cycle FIFO read latency.
// Ports:
//   i_Rclk, i_Rrst_n : read clock, async active-low reset
//   i_push           : write i_push_data at the tail
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : oldest entry (meaningful when o_count != 0)
//   o_count          : occupancy, 0..2
module rd_skid_buf #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_Rclk,
    input  logic                  i_Rrst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  do_pop;

    assign do_pop = i_pop && (o_count != 2'd0);
    assign o_head = slot0;

    // slot0 is always the head; slot1 holds the second entry when full
    always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
        if (!i_Rrst_n) begin
            slot0   <= '0;
            slot1   <= '0;
            o_count <= 2'd0;
        end else begin
            case ({i_push, do_pop})
                2'b10: begin
                    if (o_count == 2'd0) begin
                        slot0 <= i_push_data;
                    end else if (o_count == 2'd1) begin
                        slot1 <= i_push_data;
                    end
                    if (o_count != 2'd2) begin
                        o_count <= o_count + 2'd1;
                    end
                end
                2'b01: begin
                    slot0   <= slot1;
                    o_count <= o_count - 2'd1;
                end
                2'b11: begin
                    // simultaneous push/pop: count unchanged, order kept
                    if (o_count == 2'd1) begin
                        slot0 <= i_push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_framer.sv
// Read-side sequencer: issues FIFO reads, buffers returning words and wraps
// them into IDLE / SOF / data / EOF frames on a ready/valid symbol stream.
// Ports:
//   i_Rclk, i_Rrst_n          : read clock, async active-low reset
//   i_enable                  : allows new frames to start
//   i_empty, o_R_en, i_rdata  : FIFO read port (data one cycle after accept)
//   o_tx_data/o_tx_k/o_tx_valid, i_tx_ready : symbol stream to serializer
//   o_frame_active            : high in SOF/DATA/EOF
//   o_underrun                : one-cycle pulse when a frame ends for lack of data
module fifo_rd_framer
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           MAX_BURST  = 16,
    parameter int unsigned           MIN_IDLE   = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_SYM   = DATA_WIDTH'(K28_5),
    parameter logic [DATA_WIDTH-1:0] SOF_SYM    = DATA_WIDTH'(K27_7),
    parameter logic [DATA_WIDTH-1:0] EOF_SYM    = DATA_WIDTH'(K29_7)
) (
    input  logic                  i_Rclk,
    input  logic                  i_Rrst_n,
    input  logic                  i_enable,
    input  logic                  i_empty,
    output logic                  o_R_en,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_k,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_frame_active,
    output logic                  o_underrun
);

    localparam int unsigned IDLE_CW  = $clog2(MIN_IDLE + 1);
    localparam int unsigned BURST_CW = $clog2(MAX_BURST + 1);

    state_t                state;
    state_t                state_d;
    logic [IDLE_CW-1:0]    idle_cnt;
    logic [IDLE_CW-1:0]    idle_cnt_d;
    logic [BURST_CW-1:0]   burst_cnt;
    logic [BURST_CW-1:0]   burst_cnt_d;
    logic                  inflight;
    logic                  started;
    logic                  underrun_d;
    logic                  xfer;
    logic                  buf_pop;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_head;

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .i_Rclk      (i_Rclk),
        .i_Rrst_n    (i_Rrst_n),
        .i_push      (inflight),
        .i_push_data (i_rdata),
        .i_pop       (buf_pop),
        .o_head      (buf_head),
        .o_count     (buf_count)
    );

    // Only read while the buffer can still take every outstanding word
    assign o_R_en         = started && ((3'(buf_count) + 3'(inflight)) < 3'd2);
    assign xfer           = o_tx_valid && i_tx_ready;
    assign o_frame_active = (state != S_IDLE);

    // State, counters and read tracking
    always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
        if (!i_Rrst_n) begin
            state      <= S_IDLE;
            idle_cnt   <= '0;
            burst_cnt  <= '0;
            inflight   <= 1'b0;
            started    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            state      <= state_d;
            idle_cnt   <= idle_cnt_d;
            burst_cnt  <= burst_cnt_d;
            inflight   <= o_R_en && !i_empty;
            started    <= 1'b1;
            o_underrun <= underrun_d;
        end
    end

    // Next state and symbol selection
    always_comb begin
        state_d     = state;
        idle_cnt_d  = idle_cnt;
        burst_cnt_d = burst_cnt;
        underrun_d  = 1'b0;
        buf_pop     = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = IDLE_SYM;
        o_tx_k      = 1'b1;

        case (state)
            S_IDLE: begin
                o_tx_valid = started;
                if (xfer) begin
                    if (idle_cnt != IDLE_CW'(MIN_IDLE)) begin
                        idle_cnt_d = idle_cnt + IDLE_CW'(1);
                    end
                    if ((32'(idle_cnt) + 32'd1 >= MIN_IDLE) && i_enable &&
                        (buf_count != 2'd0)) begin
                        state_d = S_SOF;
                    end
                end
            end
            S_SOF: begin
                o_tx_valid = 1'b1;
                o_tx_data  = SOF_SYM;
                if (xfer) begin
                    state_d     = S_DATA;
                    burst_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (buf_count != 2'd0) begin
                    o_tx_valid = 1'b1;
                    o_tx_data  = buf_head;
                    o_tx_k     = 1'b0;
                    if (xfer) begin
                        buf_pop     = 1'b1;
                        burst_cnt_d = burst_cnt + BURST_CW'(1);
                        if (32'(burst_cnt) + 32'd1 == MAX_BURST) begin
                            state_d = S_EOF;
                        end
                    end
                end else if (!inflight && i_empty) begin
                    // nothing buffered, nothing coming: close the frame early
                    state_d    = S_EOF;
                    underrun_d = 1'b1;
                end
            end
            S_EOF: begin
                o_tx_valid = 1'b1;
                o_tx_data  = EOF_SYM;
                if (xfer) begin
                    state_d    = S_IDLE;
                    idle_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Self-checking bench for fifo_rd_framer: FIFO model, frame-level symbol
// model and a per-cycle stream checker.
module tb_fifo_rd_framer;

    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned MIN_IDLE  = 2;
    localparam logic [7:0]  IDLE_S    = 8'hBC;
    localparam logic [7:0]  SOF_S     = 8'hFB;
    localparam logic [7:0]  EOF_S     = 8'hFD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_empty = 1'b1;
    logic          o_R_en;
    logic [DW-1:0] i_rdata = '0;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_k;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b1;
    logic          o_frame_active;
    logic          o_underrun;

    always #5 clk = ~clk;

    fifo_rd_framer #(
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST),
        .MIN_IDLE   (MIN_IDLE)
    ) dut (
        .i_Rclk         (clk),
        .i_Rrst_n       (rst_n),
        .i_enable       (i_enable),
        .i_empty        (i_empty),
        .o_R_en         (o_R_en),
        .i_rdata        (i_rdata),
        .o_tx_data      (o_tx_data),
        .o_tx_k         (o_tx_k),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_frame_active (o_frame_active),
        .o_underrun     (o_underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- FIFO model (registered empty, 1-cycle read latency)
    logic [7:0] fifo_q[$];
    logic       acc_n = 1'b0;

    always @(negedge clk) acc_n = o_R_en && !i_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            i_empty <= 1'b1;
        end else if (acc_n) begin
            i_rdata <= fifo_q.pop_front();
            i_empty <= (fifo_q.size() == 0);
        end else begin
            i_empty <= (fifo_q.size() == 0);
        end
    end

    // ---------------- Frame-level model: expected non-IDLE symbols
    logic [8:0] exp_q[$];
    logic [7:0] pend_q[$];
    int         gap_q[$];
    int         fsize_q[$];
    int         ur_total = 0;

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        pend_q.push_back(w);
    endtask

    // All pending words are present before the frame starts, so they split
    // into MAX_BURST-sized frames in FIFO order.
    task automatic build_expect();
        while (pend_q.size() != 0) begin
            exp_q.push_back({1'b1, SOF_S});
            for (int i = 0; i < int'(MAX_BURST) && pend_q.size() != 0; i++)
                exp_q.push_back({1'b0, pend_q.pop_front()});
            exp_q.push_back({1'b1, EOF_S});
        end
    endtask

    // ---------------- Stream checker
    bit         in_frame = 0;
    bit         prev_hold = 0;
    logic [8:0] prev_sym = '0;
    logic [8:0] sym;
    logic [8:0] e;
    int         idle_run = 0;
    int         words_in_frame = 0;
    int         ur_in_frame = 0;
    bit         exp_fa;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pend_q.delete();
            in_frame  = 0;
            prev_hold = 0;
            idle_run  = 0;
            words_in_frame = 0;
            ur_in_frame    = 0;
        end else begin
            sym    = {o_tx_k, o_tx_data};
            exp_fa = in_frame || (o_tx_valid && sym == {1'b1, SOF_S});
            check(o_frame_active == exp_fa, "frame_active", o_frame_active, exp_fa);
            if (prev_hold)
                check(o_tx_valid && sym == prev_sym, "hold_stable",
                      {o_tx_valid, sym}, {1'b1, prev_sym});
            if (o_underrun) begin
                ur_total++;
                ur_in_frame++;
                check(o_tx_valid && sym == {1'b1, EOF_S} && words_in_frame < int'(MAX_BURST),
                      "underrun_at_eof", {o_tx_valid, sym}, {1'b1, 1'b1, EOF_S});
            end
            if (o_tx_valid && i_tx_ready) begin
                if (sym == {1'b1, IDLE_S}) begin
                    check(!in_frame, "idle_inside_frame", in_frame, 0);
                    idle_run++;
                end else if (exp_q.size() == 0) begin
                    check(0, "unexpected_symbol", sym, {1'b1, IDLE_S});
                end else begin
                    e = exp_q.pop_front();
                    check(sym == e, "symbol", sym, e);
                    if (e == {1'b1, SOF_S}) begin
                        gap_q.push_back(idle_run);
                        check(idle_run >= int'(MIN_IDLE), "min_idle", idle_run, MIN_IDLE);
                        idle_run = 0;
                        in_frame = 1;
                        words_in_frame = 0;
                        ur_in_frame    = 0;
                    end else if (e[8] == 1'b0) begin
                        words_in_frame++;
                    end else begin
                        fsize_q.push_back(words_in_frame);
                        check(ur_in_frame == int'(words_in_frame < int'(MAX_BURST)),
                              "underrun_count", ur_in_frame, words_in_frame < int'(MAX_BURST));
                        in_frame = 0;
                    end
                end
            end
            prev_hold = o_tx_valid && !i_tx_ready;
            prev_sym  = sym;
        end
    end

    // ---------------- Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || in_frame) && i < budget) begin
            tick();
            i++;
        end
        check(exp_q.size() == 0 && !in_frame, "frame_done_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_words(input int n, input int budget);
        int i = 0;
        while (!(in_frame && words_in_frame >= n) && i < budget) begin
            tick();
            i++;
        end
        check(in_frame && words_in_frame >= n, "word_wait_timeout", words_in_frame, n);
    endtask

    task automatic check_fsize(input string name, input int exp_n);
        int v = -1;
        if (fsize_q.size() != 0) v = fsize_q.pop_front();
        check(v == exp_n, name, v, exp_n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(o_tx_valid == 1'b0, {tag, "_valid"}, o_tx_valid, 0);
        check(o_R_en == 1'b0, {tag, "_r_en"}, o_R_en, 0);
        check(o_frame_active == 1'b0, {tag, "_frame_active"}, o_frame_active, 0);
        check(o_underrun == 1'b0, {tag, "_underrun"}, o_underrun, 0);
        check(o_tx_data == IDLE_S && o_tx_k == 1'b1, {tag, "_sym"},
              {o_tx_k, o_tx_data}, {1'b1, IDLE_S});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int ur_before;

    initial begin
        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");

        // Release: valid rises one cycle later; empty FIFO keeps IDLE going
        i_enable = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check(o_tx_valid == 1'b0, "valid_before_started", o_tx_valid, 0);
        tick();
        check(o_tx_valid == 1'b1, "valid_after_release", o_tx_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check(o_R_en == 1'b1 && o_tx_k && o_tx_data == IDLE_S && !o_frame_active,
                  "empty_idle", {o_R_en, o_tx_k, o_tx_data, o_frame_active},
                  {1'b1, 1'b1, IDLE_S, 1'b0});
            tick();
        end

        // Three words A,B,C: one short frame with one underrun
        i_enable = 1'b0;
        ur_before = ur_total;
        push_word(8'hA1); push_word(8'hB2); push_word(8'hC3);
        build_expect();
        repeat (10) tick();
        i_enable = 1'b1;
        wait_done(200);
        check(ur_total - ur_before == 1, "abc_underruns", ur_total - ur_before, 1);
        check_fsize("abc_frame_len", 3);

        // Twenty words: 16-word frame, exactly MIN_IDLE idles, 4-word frame
        i_enable = 1'b0;
        gap_q.delete();
        ur_before = ur_total;
        for (int i = 1; i <= 20; i++) push_word(8'(i));
        build_expect();
        repeat (5) tick();
        i_enable = 1'b1;
        wait_done(400);
        check_fsize("burst_frame1_len", 16);
        check_fsize("burst_frame2_len", 4);
        check(gap_q.size() == 2 && gap_q[gap_q.size()-1] == 2, "burst_gap",
              (gap_q.size() == 2) ? gap_q[1] : -1, 2);
        check(ur_total - ur_before == 1, "burst_underruns", ur_total - ur_before, 1);

        // Random backpressure at 50%
        i_enable = 1'b0;
        for (int i = 0; i < 24; i++) push_word(8'($urandom_range(0, 255)));
        build_expect();
        repeat (5) tick();
        i_enable = 1'b1;
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || in_frame); i++) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        i_tx_ready = 1'b1;
        check(exp_q.size() == 0 && !in_frame, "random_ready_done", exp_q.size(), 0);
        check_fsize("random_frame1_len", 16);
        check_fsize("random_frame2_len", 8);

        // Enable dropped mid-frame: frame completes, then no new SOF
        i_enable = 1'b0;
        for (int i = 0; i < 10; i++) push_word(8'h40 + 8'(i));
        build_expect();
        repeat (5) tick();
        i_enable = 1'b1;
        wait_words(5, 200);
        i_enable = 1'b0;
        wait_done(200);
        check_fsize("enable_drop_frame_len", 10);
        push_word(8'h61); push_word(8'h62); push_word(8'h63);
        repeat (30) tick();
        check(o_frame_active == 1'b0, "disabled_no_frame", o_frame_active, 0);
        check(o_R_en == 1'b0, "disabled_buffer_full", o_R_en, 0);
        build_expect();
        i_enable = 1'b1;
        wait_done(200);
        check_fsize("reenable_frame_len", 3);

        // Reset mid-DATA with two buffered words
        i_enable = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h70 + 8'(i));
        build_expect();
        repeat (5) tick();
        i_enable = 1'b1;
        wait_words(2, 200);
        i_tx_ready = 1'b0;
        repeat (4) tick();
        check(o_R_en == 1'b0, "stall_buffer_full", o_R_en, 0);
        check(o_tx_valid && !o_tx_k, "stall_in_data", {o_tx_valid, o_tx_k}, 2'b10);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        tick();
        tick();
        i_tx_ready = 1'b1;
        rst_n = 1'b1;
        push_word(8'h51); push_word(8'h52); push_word(8'h53);
        build_expect();
        wait_done(200);
        check_fsize("post_reset_frame_len", 3);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_framer.md
Name: fifo_rd_framer

Overview:
Read-side sequencer for the SerDes async FIFO. It sits in the read clock domain between the FIFO read port and the serializer. It issues FIFO reads, absorbs the one-cycle read latency in a 2-entry skid buffer, and wraps the data into frames: IDLE fill, SOF, up to MAX_BURST data words, EOF. Frames are delivered over a ready/valid symbol interface.

Parameters:
DATA_WIDTH, 8, width of FIFO word and of each output symbol
MAX_BURST, 16, maximum data words per frame (>=1)
MIN_IDLE, 2, minimum IDLE symbols transferred between frames (>=1)
IDLE_SYM, 8'hBC, control symbol for fill (K28.5)
SOF_SYM, 8'hFB, start-of-frame control symbol (K27.7)
EOF_SYM, 8'hFD, end-of-frame control symbol (K29.7)

Ports:
i_Rclk  in  1  read-domain clock
i_Rrst_n  in  1  asynchronous active-low reset
i_enable  in  1  permits starting new frames; a frame in progress always completes
i_empty  in  1  FIFO empty flag (registered, read domain)
o_R_en  out  1  FIFO read request; a read is accepted when o_R_en && !i_empty
i_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
o_tx_data  out  DATA_WIDTH  symbol to serializer
o_tx_k  out  1  1 = control symbol, 0 = data
o_tx_valid  out  1  symbol valid
i_tx_ready  in  1  serializer accepts symbol; transfer = o_tx_valid && i_tx_ready
o_frame_active  out  1  high in SOF/DATA/EOF states
o_underrun  out  1  one-cycle pulse when a frame is cut short because no data is available

Behaviour:
- Clock and reset: one clock, i_Rclk. i_Rrst_n is asynchronous and active-low.
- Reset values: state=IDLE, idle_cnt=0, burst_cnt=0, buffer empty, inflight=0, started=0. Outputs: o_tx_valid=0, o_R_en=0, o_frame_active=0, o_underrun=0. With state=IDLE, o_tx_data=IDLE_SYM and o_tx_k=1.
- started is set to 1 one cycle after reset release and stays set.
- Read issue: o_R_en = started && (buf_count + inflight < 2).
- inflight: register, set to (o_R_en && !i_empty) each cycle.
- Capture: i_rdata is pushed into the buffer the cycle after inflight is set.
- Buffer can never overflow: occupancy plus in-flight reads never exceeds 2.
- Push and pop may happen in the same cycle; the count is unchanged and FIFO order is preserved.
- Output stability: while o_tx_valid && !i_tx_ready, o_tx_data and o_tx_k are held. All state advances occur only on a transfer, except the DATA underrun exit.
- Prefetch: reads continue in every state, including across frame boundaries. Leftover buffered words start the next frame.
- FSM states are IDLE, SOF, DATA, EOF.
- IDLE:
  - Presents IDLE_SYM, k=1, valid=started.
  - On transfer, idle_cnt increments, saturating at MIN_IDLE.
  - Go to SOF on a transfer where (idle_cnt+1 >= MIN_IDLE) && i_enable && buf_count > 0.
- SOF:
  - Presents SOF_SYM, k=1.
  - On transfer: go to DATA and clear burst_cnt.
  - The buffer is not popped in SOF, so DATA always starts with at least one word.
- DATA:
  - If buf_count > 0: present buffer head, k=0, valid=1. On transfer, pop and increment burst_cnt. When burst_cnt+1 == MAX_BURST, go to EOF.
  - If buf_count == 0: o_tx_valid=0 (bubble).
  - If buf_count == 0 && inflight == 0 && i_empty: go to EOF next cycle and pulse o_underrun. The frame keeps its data words.
- EOF:
  - Presents EOF_SYM, k=1.
  - On transfer: go to IDLE and clear idle_cnt.
- i_enable deasserted mid-frame: no effect until IDLE; then the block stays in IDLE indefinitely.
- Reset mid-frame: immediate return to reset values. Buffered words are discarded; the FIFO is reset alongside.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - state enum {S_IDLE, S_SOF, S_DATA, S_EOF}
  - default symbol constants K28_5, K27_7, K29_7
- Sub-module rd_skid_buf: 2-entry FIFO with push/pop/head/count.
- The FSM, counters and read issue stay in fifo_rd_framer.

Test Plan:
- Reset, then i_empty=1 with ready=1 -> o_tx_valid rises 1 cycle after release. Continuous IDLE_SYM with k=1; o_R_en=1, no reads accepted, o_frame_active=0.
- Preload 3 words A,B,C, ready=1, MIN_IDLE=2 -> output is IDLE, IDLE, SOF, A, B, C, EOF, IDLE. DATA words have k=0. o_underrun pulses once after C.
- FIFO holds 20 words, MAX_BURST=16 -> frame 1 carries words 1..16 then EOF. Exactly 2 IDLE follow, then SOF with words 17..20. No word is lost or duplicated across the boundary.
- i_tx_ready toggled randomly at 50% -> each symbol is held stable while not ready, and the data sequence matches FIFO order.
- i_enable dropped during word 5 of a 10-word frame -> the frame completes (10 words + EOF). Then IDLE continues with no new SOF until i_enable=1.
- Assert i_Rrst_n low mid-DATA while holding 2 buffered words -> outputs return to reset values the same cycle. After release, the first frame starts only with newly read data.
